// File: rtl/psw_flag_unit_if.sv
// Adder-to-flag-unit bus: the adder result and control strobes in, registered
// result, flags, branch outcome and shadow status out.
interface psw_flag_unit_if #(
  parameter int WIDTH = 16
);
  logic             alu_valid;
  logic [WIDTH-1:0] Sum;
  logic             Cout;
  logic             Z;
  logic             N;
  logic             A_msb;
  logic             B_msb;
  logic             ALUop;
  logic             Flag;
  logic             psw_we;
  logic [3:0]       psw_wdata;
  logic             int_save;
  logic             int_restore;
  logic             br_req;
  logic [2:0]       cond;

  logic [WIDTH-1:0] ALUout;
  logic [3:0]       PSW;
  logic             PSW_C;
  logic             br_valid;
  logic             br_taken;
  logic             shadow_full;
  logic             shadow_err;

  modport master (
    output alu_valid, Sum, Cout, Z, N, A_msb, B_msb, ALUop, Flag,
           psw_we, psw_wdata, int_save, int_restore, br_req, cond,
    input  ALUout, PSW, PSW_C, br_valid, br_taken, shadow_full, shadow_err
  );

  modport slave (
    input  alu_valid, Sum, Cout, Z, N, A_msb, B_msb, ALUop, Flag,
           psw_we, psw_wdata, int_save, int_restore, br_req, cond,
    output ALUout, PSW, PSW_C, br_valid, br_taken, shadow_full, shadow_err
  );
endinterface

// File: rtl/psw_flag_unit.sv
// Registers the adder result and PSW flags {V,N,Z,C}, evaluates branch
// conditions against the pre-edge PSW and keeps a one-deep interrupt shadow.
module psw_flag_unit #(
  parameter int WIDTH = 16
) (
  input logic            clk,
  input logic            rst_n,
  psw_flag_unit_if.slave bus
);

  typedef enum logic {
    EMPTY = 1'b0,
    FULL  = 1'b1
  } shadow_state_e;

  shadow_state_e    state_q, state_d;
  logic [WIDTH-1:0] alu_out_q;
  logic [3:0]       psw_q;
  logic [3:0]       shadow_q;
  logic             shadow_err_q;
  logic             br_valid_q;
  logic             br_taken_q;

  logic             shadow_load;
  logic             shadow_restore;
  logic             err_set;
  logic             ovf;
  logic             cond_true;

  // Subtract overflows when operand signs differ, i.e. B's sign after inversion
  // matches A's; the stored C stays the raw adder carry-out in both cases.
  assign ovf = (bus.A_msb == (bus.B_msb ^ bus.ALUop)) &&
               (bus.Sum[WIDTH-1] != bus.A_msb);

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d        = state_q;
    shadow_load    = 1'b0;
    shadow_restore = 1'b0;
    err_set        = 1'b0;
    unique case (state_q)
      EMPTY: begin
        if (bus.int_restore) err_set = 1'b1;
        if (bus.int_save) begin
          shadow_load = 1'b1;
          state_d     = FULL;
        end
      end
      FULL: begin
        if (bus.int_restore) begin
          shadow_restore = 1'b1;
          state_d        = EMPTY;
        end else if (bus.int_save) begin
          err_set = 1'b1;
        end
      end
      default: state_d = EMPTY;
    endcase
  end

  always_comb begin
    cond_true = 1'b0;
    unique case (bus.cond)
      3'b000: cond_true = psw_q[1];
      3'b001: cond_true = !psw_q[1];
      3'b010: cond_true = psw_q[0];
      3'b011: cond_true = !psw_q[0];
      3'b100: cond_true = psw_q[2];
      3'b101: cond_true = psw_q[3];
      3'b110: cond_true = 1'b1;
      3'b111: cond_true = 1'b0;
      default: cond_true = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= EMPTY;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values; the branch evaluation relies on seeing the old PSW.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_out_q    <= '0;
      psw_q        <= '0;
      shadow_q     <= '0;
      shadow_err_q <= 1'b0;
      br_valid_q   <= 1'b0;
      br_taken_q   <= 1'b0;
    end else begin
      if (bus.alu_valid) alu_out_q <= bus.Sum;

      // A restore strobe owns the PSW this cycle even when it errors out.
      if (bus.int_restore) begin
        if (shadow_restore) psw_q <= shadow_q;
      end else if (bus.psw_we) begin
        psw_q <= bus.psw_wdata;
      end else if (bus.alu_valid && bus.Flag) begin
        psw_q <= {ovf, bus.N, bus.Z, bus.Cout};
      end

      if (shadow_load) shadow_q <= psw_q;
      if (err_set) shadow_err_q <= 1'b1;

      br_valid_q <= bus.br_req;
      br_taken_q <= bus.br_req && cond_true;
    end
  end

  assign bus.ALUout      = alu_out_q;
  assign bus.PSW         = psw_q;
  assign bus.PSW_C       = psw_q[0];
  assign bus.br_valid    = br_valid_q;
  assign bus.br_taken    = br_taken_q;
  assign bus.shadow_full = (state_q == FULL);
  assign bus.shadow_err  = shadow_err_q;

endmodule

// File: tb/tb_psw_flag_unit.sv
// Directed bench for psw_flag_unit: hand-computed vectors for capture, flags,
// write priority, shadow save/restore and branch evaluation.
module tb_psw_flag_unit;
  localparam int WIDTH = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;

  psw_flag_unit_if #(.WIDTH(WIDTH)) bus ();

  psw_flag_unit #(.WIDTH(WIDTH)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle();
    bus.alu_valid   = 1'b0;
    bus.Sum         = '0;
    bus.Cout        = 1'b0;
    bus.Z           = 1'b0;
    bus.N           = 1'b0;
    bus.A_msb       = 1'b0;
    bus.B_msb       = 1'b0;
    bus.ALUop       = 1'b0;
    bus.Flag        = 1'b0;
    bus.psw_we      = 1'b0;
    bus.psw_wdata   = 4'h0;
    bus.int_save    = 1'b0;
    bus.int_restore = 1'b0;
    bus.br_req      = 1'b0;
    bus.cond        = 3'b000;
  endtask

  // Advance one edge and settle away from it; inputs then return to idle.
  task automatic step();
    @(posedge clk);
    #1;
    idle();
  endtask

  task automatic alu(input logic [15:0] sum, input logic cout, input logic z,
                     input logic n, input logic a, input logic b,
                     input logic op, input logic flag);
    bus.alu_valid = 1'b1;
    bus.Sum       = sum;
    bus.Cout      = cout;
    bus.Z         = z;
    bus.N         = n;
    bus.A_msb     = a;
    bus.B_msb     = b;
    bus.ALUop     = op;
    bus.Flag      = flag;
  endtask

  task automatic wr_psw(input logic [3:0] v);
    bus.psw_we    = 1'b1;
    bus.psw_wdata = v;
  endtask

  task automatic check_zero(input string tag);
    check({tag, ".alu"}, 32'(bus.ALUout), 32'h0);
    check({tag, ".psw"}, 32'(bus.PSW), 32'h0);
    check({tag, ".c"},   32'(bus.PSW_C), 32'h0);
    check({tag, ".bv"},  32'(bus.br_valid), 32'h0);
    check({tag, ".bt"},  32'(bus.br_taken), 32'h0);
    check({tag, ".sf"},  32'(bus.shadow_full), 32'h0);
    check({tag, ".se"},  32'(bus.shadow_err), 32'h0);
  endtask

  typedef struct {
    logic [2:0] cond;
    logic       taken;
  } br_vec_t;

  initial begin
    br_vec_t sweep[6];

    idle();
    // Reset held with inputs toggling
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      bus.alu_valid   = 1'($urandom);
      bus.Sum         = 16'($urandom);
      bus.Cout        = 1'($urandom);
      bus.Flag        = 1'($urandom);
      bus.psw_we      = 1'($urandom);
      bus.psw_wdata   = 4'($urandom);
      bus.int_save    = 1'($urandom);
      bus.int_restore = 1'($urandom);
      bus.br_req      = 1'($urandom);
      bus.cond        = 3'($urandom);
    end
    #1;
    check_zero("rst_hold");
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    step();
    check_zero("rst_rel");

    // Subtract equal operands: no borrow so C=1, Z=1
    alu(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    step();
    check("sub_eq.alu", 32'(bus.ALUout), 32'h0000);
    check("sub_eq.psw", 32'(bus.PSW), 32'b0011);
    check("sub_eq.c",   32'(bus.PSW_C), 32'h1);
    bus.br_req = 1'b1;
    bus.cond   = 3'b000;
    step();
    check("eq.bv", 32'(bus.br_valid), 32'h1);
    check("eq.bt", 32'(bus.br_taken), 32'h1);
    step();
    check("eq.bv_pulse", 32'(bus.br_valid), 32'h0);

    // 8001 - 0003 = 7FFE, signed overflow
    alu(16'h7FFE, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    step();
    check("ovf_sub.alu", 32'(bus.ALUout), 32'h7FFE);
    check("ovf_sub.psw", 32'(bus.PSW), 32'b1001);
    // FFFF + 0002 = 0001, carry but no overflow
    alu(16'h0001, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1);
    step();
    check("add_c.alu", 32'(bus.ALUout), 32'h0001);
    check("add_c.psw", 32'(bus.PSW), 32'b0001);
    // 7FFF + 0001 = 8000, add overflow
    alu(16'h8000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    check("ovf_add.psw", 32'(bus.PSW), 32'b1100);

    // Flag=0 holds PSW while ALUout still captures
    wr_psw(4'b1001);
    step();
    check("hold.load", 32'(bus.PSW), 32'b1001);
    alu(16'h1234, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    step();
    check("hold.alu", 32'(bus.ALUout), 32'h1234);
    check("hold.psw", 32'(bus.PSW), 32'b1001);
    // Direct write beats ALU flag update
    alu(16'h0000, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    wr_psw(4'b0100);
    step();
    check("prio.psw", 32'(bus.PSW), 32'b0100);
    check("prio.alu", 32'(bus.ALUout), 32'h0000);
    // alu_valid=0 ignores Flag and holds ALUout
    bus.Sum  = 16'hBEEF;
    bus.Flag = 1'b1;
    bus.Z    = 1'b1;
    step();
    check("novalid.alu", 32'(bus.ALUout), 32'h0000);
    check("novalid.psw", 32'(bus.PSW), 32'b0100);

    // Shadow save / restore
    wr_psw(4'b0101);
    step();
    bus.int_save = 1'b1;
    step();
    check("save.full", 32'(bus.shadow_full), 32'h1);
    check("save.err",  32'(bus.shadow_err), 32'h0);
    wr_psw(4'b0000);
    step();
    check("save.clobber", 32'(bus.PSW), 32'b0000);
    bus.int_restore = 1'b1;
    step();
    check("rest.psw",  32'(bus.PSW), 32'b0101);
    check("rest.full", 32'(bus.shadow_full), 32'h0);
    check("rest.err",  32'(bus.shadow_err), 32'h0);
    bus.int_restore = 1'b1;
    step();
    check("rest2.err", 32'(bus.shadow_err), 32'h1);
    check("rest2.psw", 32'(bus.PSW), 32'b0101);
    // Both strobes in EMPTY: save proceeds, error stays set
    bus.int_save    = 1'b1;
    bus.int_restore = 1'b1;
    step();
    check("both_e.full", 32'(bus.shadow_full), 32'h1);
    check("both_e.psw",  32'(bus.PSW), 32'b0101);
    // Both strobes in FULL: restore wins
    wr_psw(4'b1000);
    step();
    bus.int_save    = 1'b1;
    bus.int_restore = 1'b1;
    step();
    check("both_f.full", 32'(bus.shadow_full), 32'h0);
    check("both_f.psw",  32'(bus.PSW), 32'b0101);

    // Branch evaluates the pre-edge PSW
    wr_psw(4'b0000);
    step();
    bus.br_req = 1'b1;
    bus.cond   = 3'b000;
    alu(16'h0000, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    step();
    check("same_edge.bv",  32'(bus.br_valid), 32'h1);
    check("same_edge.bt",  32'(bus.br_taken), 32'h0);
    check("same_edge.psw", 32'(bus.PSW), 32'b0010);

    // Back-to-back requests against PSW=0010
    sweep[0] = '{3'b000, 1'b1};
    sweep[1] = '{3'b110, 1'b1};
    sweep[2] = '{3'b111, 1'b0};
    sweep[3] = '{3'b001, 1'b0};
    sweep[4] = '{3'b011, 1'b1};
    sweep[5] = '{3'b010, 1'b0};
    foreach (sweep[i]) begin
      bus.br_req = 1'b1;
      bus.cond   = sweep[i].cond;
      step();
      check($sformatf("br%0d.bv", i), 32'(bus.br_valid), 32'h1);
      check($sformatf("br%0d.bt", i), 32'(bus.br_taken), 32'(sweep[i].taken));
    end
    wr_psw(4'b1100);
    step();
    bus.br_req = 1'b1;
    bus.cond   = 3'b100;
    step();
    check("mi.bt", 32'(bus.br_taken), 32'h1);
    bus.br_req = 1'b1;
    bus.cond   = 3'b101;
    step();
    check("vs.bt", 32'(bus.br_taken), 32'h1);

    // Reset mid-operation drops a pending evaluation
    @(negedge clk);
    bus.br_req = 1'b1;
    bus.cond   = 3'b110;
    rst_n      = 1'b0;
    @(posedge clk);
    #1;
    check_zero("mid_rst");
    @(negedge clk);
    idle();
    rst_n = 1'b1;
    step();
    check("post_rst.bv", 32'(bus.br_valid), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
